// File: rtl/booth_pkg.sv
// booth_pkg: Booth selector codes and encoder state encoding shared by encoder, decoder and accumulator.
package booth_pkg;
  localparam logic [2:0] SEL_ZERO0 = 3'd0;
  localparam logic [2:0] SEL_P1A   = 3'd1;
  localparam logic [2:0] SEL_P1B   = 3'd2;
  localparam logic [2:0] SEL_P2    = 3'd3;
  localparam logic [2:0] SEL_M2    = 3'd4;
  localparam logic [2:0] SEL_M1A   = 3'd5;
  localparam logic [2:0] SEL_M1B   = 3'd6;
  localparam logic [2:0] SEL_ZERO7 = 3'd7;
  typedef enum logic {ST_IDLE, ST_EMIT} state_t;
endpackage

// File: rtl/booth_encoder_seq.sv
// booth_encoder_seq: emits radix-4 Booth selectors of a latched multiplier, LSB group first, one per handshake.
module booth_encoder_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int GROUPS = WIDTH / 2,
  localparam int IDXW = (GROUPS > 1) ? $clog2(GROUPS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] b,
  output logic             sel_valid,
  input  logic             sel_ready,
  output logic [2:0]       sel,
  output logic [IDXW-1:0]  sel_idx,
  output logic             sel_last,
  output logic             busy,
  output logic             done
);
  state_t state, state_n;
  logic signed [WIDTH-1:0] mreg;
  logic prev;
  logic [IDXW-1:0] idx;
  logic last;
  logic fire;
  assign fire = (state == ST_EMIT) && sel_ready;
  always_comb begin
    state_n = state;
    state_n = (state == ST_IDLE) ? (start ? ST_EMIT : ST_IDLE)
                                 : ((fire && last) ? ST_IDLE : ST_EMIT);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= ST_IDLE;
    else state <= state_n;
  // sel_last is precomputed one transfer early so every output comes straight from a flop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mreg <= '0;
      prev <= 1'b0;
      idx  <= '0;
      last <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= fire && last;
      if (state == ST_IDLE && start) begin
        mreg <= b;
        prev <= 1'b0;
        idx  <= '0;
        last <= 1'b0;
      end else if (fire) begin
        prev <= mreg[1];
        mreg <= mreg >>> 2;
        idx  <= idx + IDXW'(1);
        last <= (idx == IDXW'(GROUPS - 2));
      end
    end
  end
  assign sel_valid = (state == ST_EMIT);
  assign busy      = (state == ST_EMIT);
  assign sel       = {mreg[1], mreg[0], prev};
  assign sel_idx   = idx;
  assign sel_last  = last;
endmodule

// File: tb/tb_booth_encoder_seq.sv
// tb_booth_encoder_seq: randomized and directed checks of the Booth encoder against an arithmetic reference.
module tb_booth_encoder_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [7:0] b = 8'h00;
  logic sel_valid, sel_ready, sel_last, busy, done;
  logic [2:0] sel;
  logic [1:0] sel_idx;
  int passed = 0;
  int total = 0;
  logic [2:0] q_sel[$];
  int q_idx[$];
  logic q_last[$];
  int done_c;
  logic overlap;

  booth_encoder_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .b(b),
    .sel_valid(sel_valid), .sel_ready(sel_ready), .sel(sel),
    .sel_idx(sel_idx), .sel_last(sel_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // group i of the Booth recoding looks at bits 2i+1..2i-1 of (b with a zero appended below)
  function automatic logic [2:0] exp_sel(input logic [7:0] v, input int i);
    int bx;
    bx = int'(v) * 2;
    return 3'((bx >> (2 * i)) & 7);
  endfunction

  function automatic int digit(input logic [2:0] s);
    case (s)
      3'd1, 3'd2: return 1;
      3'd3:       return 2;
      3'd4:       return -2;
      3'd5, 3'd6: return -1;
      default:    return 0;
    endcase
  endfunction

  task automatic start_op(input logic [7:0] v);
    start = 1'b1;
    b = v;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic collect(input logic [31:0] rmask, input int inj_at, input logic chain, input logic [7:0] nb);
    q_sel.delete();
    q_idx.delete();
    q_last.delete();
    done_c = 0;
    overlap = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      sel_ready = (c <= 32) ? rmask[c-1] : 1'b1;
      start = (c == inj_at);
      if (c == inj_at) b = 8'hFF;
      @(negedge clk);
      if (done && sel_valid) overlap = 1'b1;
      if (sel_valid && sel_ready) begin
        q_sel.push_back(sel);
        q_idx.push_back(int'(sel_idx));
        q_last.push_back(sel_last);
      end
      if (done) begin
        done_c = c;
        if (chain) begin
          start = 1'b1;
          b = nb;
        end
        @(posedge clk);
        #1 start = 1'b0;
        break;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    sel_ready = 1'b1;
    repeat (2) @(negedge clk);
    total += 6;
    if (sel_valid !== 1'b0) $display("FAIL reset_sel_valid got %b want 0", sel_valid); else passed++;
    if (sel !== 3'd0) $display("FAIL reset_sel got %0d want 0", sel); else passed++;
    if (sel_idx !== 2'd0) $display("FAIL reset_sel_idx got %0d want 0", sel_idx); else passed++;
    if (sel_last !== 1'b0) $display("FAIL reset_sel_last got %b want 0", sel_last); else passed++;
    if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_patterns;
    logic [7:0] vals[5] = '{8'h55, 8'hFF, 8'h80, 8'h01, 8'h00};
    foreach (vals[k]) begin
      start_op(vals[k]);
      collect(32'hFFFF_FFFF, 0, 1'b0, 8'h00);
      total++;
      if (q_sel.size() != 4) $display("FAIL pat_%h_count got %0d want 4", vals[k], q_sel.size()); else passed++;
      for (int i = 0; i < 4 && i < q_sel.size(); i++) begin
        total += 3;
        if (q_sel[i] !== exp_sel(vals[k], i)) $display("FAIL pat_%h_sel%0d got %0d want %0d", vals[k], i, q_sel[i], exp_sel(vals[k], i)); else passed++;
        if (q_idx[i] != i) $display("FAIL pat_%h_idx%0d got %0d want %0d", vals[k], i, q_idx[i], i); else passed++;
        if (q_last[i] !== (i == 3)) $display("FAIL pat_%h_last%0d got %b want %b", vals[k], i, q_last[i], i == 3); else passed++;
      end
      total += 2;
      if (done_c != 5) $display("FAIL pat_%h_done_cycle got %0d want 5", vals[k], done_c); else passed++;
      if (overlap) $display("FAIL pat_%h_done_overlap got 1 want 0", vals[k]); else passed++;
    end
  endtask

  task automatic test_stall;
    logic pat[7] = '{1, 0, 0, 1, 0, 1, 1};
    logic [2:0] h_sel;
    logic [1:0] h_idx;
    logic h_last, held, unstable;
    int n, dc;
    n = 0;
    dc = 0;
    held = 1'b0;
    unstable = 1'b0;
    start_op(8'h55);
    for (int c = 1; c <= 20; c++) begin
      sel_ready = (c <= 7) ? pat[c-1] : 1'b1;
      @(negedge clk);
      if (held && (!sel_valid || sel !== h_sel || sel_idx !== h_idx || sel_last !== h_last)) unstable = 1'b1;
      held = sel_valid && !sel_ready;
      h_sel = sel;
      h_idx = sel_idx;
      h_last = sel_last;
      if (sel_valid && sel_ready) begin
        total++;
        if (sel !== 3'd2 || int'(sel_idx) != n) $display("FAIL stall_group%0d got sel %0d idx %0d want sel 2 idx %0d", n, sel, sel_idx, n); else passed++;
        n++;
      end
      if (done) begin
        dc = c;
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
    end
    total += 3;
    if (unstable) $display("FAIL stall_hold got unstable want stable"); else passed++;
    if (n != 4) $display("FAIL stall_count got %0d want 4", n); else passed++;
    if (dc != 8) $display("FAIL stall_done_cycle got %0d want 8", dc); else passed++;
  endtask

  task automatic test_back_to_back;
    start_op(8'h55);
    collect(32'hFFFF_FFFF, 2, 1'b1, 8'hFF);
    total += 2;
    if (q_sel.size() != 4) $display("FAIL ignore_count got %0d want 4", q_sel.size()); else passed++;
    if (done_c != 5) $display("FAIL ignore_done_cycle got %0d want 5", done_c); else passed++;
    for (int i = 0; i < q_sel.size(); i++) begin
      total++;
      if (q_sel[i] !== 3'd2) $display("FAIL ignore_sel%0d got %0d want 2", i, q_sel[i]); else passed++;
    end
    collect(32'hFFFF_FFFF, 0, 1'b0, 8'h00);
    total += 2;
    if (q_sel.size() != 4) $display("FAIL b2b_count got %0d want 4", q_sel.size()); else passed++;
    if (done_c != 5) $display("FAIL b2b_done_cycle got %0d want 5", done_c); else passed++;
    for (int i = 0; i < q_sel.size(); i++) begin
      total++;
      if (q_sel[i] !== exp_sel(8'hFF, i)) $display("FAIL b2b_sel%0d got %0d want %0d", i, q_sel[i], exp_sel(8'hFF, i)); else passed++;
    end
  endtask

  task automatic test_mid_reset;
    logic saw;
    saw = 1'b0;
    start_op(8'h55);
    sel_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    total += 5;
    if (sel_valid !== 1'b0) $display("FAIL midrst_sel_valid got %b want 0", sel_valid); else passed++;
    if (sel !== 3'd0) $display("FAIL midrst_sel got %0d want 0", sel); else passed++;
    if (sel_idx !== 2'd0) $display("FAIL midrst_sel_idx got %0d want 0", sel_idx); else passed++;
    if (busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", busy); else passed++;
    if (sel_last !== 1'b0) $display("FAIL midrst_sel_last got %b want 0", sel_last); else passed++;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done || sel_valid) saw = 1'b1;
      @(posedge clk);
      #1;
    end
    total++;
    if (saw) $display("FAIL midrst_quiet got activity want none"); else passed++;
    start_op(8'h01);
    collect(32'hFFFF_FFFF, 0, 1'b0, 8'h00);
    total++;
    if (q_sel.size() != 4) $display("FAIL midrst_count got %0d want 4", q_sel.size()); else passed++;
    for (int i = 0; i < q_sel.size(); i++) begin
      total++;
      if (q_sel[i] !== exp_sel(8'h01, i)) $display("FAIL midrst_sel%0d got %0d want %0d", i, q_sel[i], exp_sel(8'h01, i)); else passed++;
    end
  endtask

  task automatic test_random;
    logic [7:0] rb, ra;
    int acc, want;
    for (int t = 0; t < 30; t++) begin
      rb = 8'($urandom);
      ra = 8'($urandom);
      start_op(rb);
      collect($urandom | $urandom, 0, 1'b0, 8'h00);
      acc = 0;
      for (int i = 0; i < q_sel.size(); i++)
        acc += digit(q_sel[i]) * int'($signed(ra)) * (4 ** q_idx[i]);
      want = int'($signed(rb)) * int'($signed(ra));
      total += 3;
      if (q_sel.size() != 4) $display("FAIL rand%0d_count got %0d want 4", t, q_sel.size()); else passed++;
      if (acc != want) $display("FAIL rand%0d_product b=%h a=%h got %0d want %0d", t, rb, ra, acc, want); else passed++;
      if (done_c == 0 || overlap) $display("FAIL rand%0d_done got cycle %0d overlap %b want done without overlap", t, done_c, overlap); else passed++;
    end
  endtask

  initial begin
    sel_ready = 1'b1;
    test_reset();
    test_patterns();
    test_stall();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
